// File: rtl/prog_clk_divider_if.sv
// rtl/prog_clk_divider_if.sv - control and output bundle for the programmable clock divider
interface prog_clk_divider_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 24
);
    logic [NUM_CH-1:0]       I_EN;
    logic [NUM_CH-1:0]       I_LOAD;
    logic [NUM_CH*CNT_W-1:0] I_DIV;
    logic [NUM_CH*CNT_W-1:0] I_HIGH;
    logic [NUM_CH-1:0]       O_CLK;
    logic [NUM_CH-1:0]       O_TICK;
    logic [NUM_CH-1:0]       O_PEND;

    modport master (
        output I_EN, I_LOAD, I_DIV, I_HIGH,
        input  O_CLK, O_TICK, O_PEND
    );

    modport slave (
        input  I_EN, I_LOAD, I_DIV, I_HIGH,
        output O_CLK, O_TICK, O_PEND
    );
endinterface

// File: rtl/prog_clk_divider.sv
// rtl/prog_clk_divider.sv - multi-channel programmable clock divider with glitch-free reload
module prog_clk_divider #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 24,
    parameter int DEF_DIV = 5000000
) (
    input logic               I_CLK,
    input logic               I_RST,
    prog_clk_divider_if.slave bus
);
    localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_DIV / 2);

    typedef enum logic {IDLE, RUN} state_t;

    logic [NUM_CH-1:0] clk_vec;
    logic [NUM_CH-1:0] tick_vec;
    logic [NUM_CH-1:0] pend_vec;

    assign bus.O_CLK  = clk_vec;
    assign bus.O_TICK = tick_vec;
    assign bus.O_PEND = pend_vec;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] n_act_q, n_act_d, h_act_q, h_act_d;
        logic [CNT_W-1:0] n_sh_q, n_sh_d, h_sh_q, h_sh_d;
        logic             clk_q, clk_d, tick_q, tick_d, pend_q, pend_d;
        logic [CNT_W-1:0] div_in, high_in, n_eff;
        logic             wrap;

        assign div_in  = bus.I_DIV[i*CNT_W +: CNT_W];
        assign high_in = bus.I_HIGH[i*CNT_W +: CNT_W];
        // Ratios below 2 cannot form a high and a low phase, so they run at 2.
        assign n_eff   = (n_act_q < CNT_W'(2)) ? CNT_W'(2) : n_act_q;
        // Active settings only change when cnt is 0, so >= is equivalent to == here.
        assign wrap    = (cnt_q >= n_eff - CNT_W'(1));

        assign clk_vec[i]  = clk_q;
        assign tick_vec[i] = tick_q;
        assign pend_vec[i] = pend_q;

        // Channel state register; reset restores the default ratio and drops pending loads.
        always_ff @(posedge I_CLK or posedge I_RST) begin
            if (I_RST) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                n_act_q <= DEF_N;
                h_act_q <= DEF_H;
                n_sh_q  <= DEF_N;
                h_sh_q  <= DEF_H;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
                pend_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                n_act_q <= n_act_d;
                h_act_q <= h_act_d;
                n_sh_q  <= n_sh_d;
                h_sh_q  <= h_sh_d;
                clk_q   <= clk_d;
                tick_q  <= tick_d;
                pend_q  <= pend_d;
            end
        end

        // Next-state: count through the period, swap in shadow settings only on the wrap edge.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            n_act_d = n_act_q;
            h_act_d = h_act_q;
            n_sh_d  = n_sh_q;
            h_sh_d  = h_sh_q;
            clk_d   = 1'b0;
            tick_d  = 1'b0;
            pend_d  = pend_q;
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    // A load left pending when the channel was disabled is applied while idle.
                    if (pend_q) begin
                        n_act_d = n_sh_q;
                        h_act_d = h_sh_q;
                        pend_d  = 1'b0;
                    end
                    if (bus.I_LOAD[i]) begin
                        n_act_d = div_in;
                        h_act_d = high_in;
                        n_sh_d  = div_in;
                        h_sh_d  = high_in;
                        pend_d  = 1'b0;
                    end
                    if (bus.I_EN[i]) begin
                        state_d = RUN;
                        tick_d  = 1'b1;
                        clk_d   = (h_act_q != '0);
                    end
                end
                RUN: begin
                    if (!bus.I_EN[i]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (wrap) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                        if (pend_q) begin
                            n_act_d = n_sh_q;
                            h_act_d = h_sh_q;
                            pend_d  = 1'b0;
                            clk_d   = (h_sh_q != '0);
                        end else begin
                            clk_d   = (h_act_q != '0);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        clk_d = (cnt_d < h_act_q);
                    end
                    // A new load wins over the wrap-edge swap: it becomes the next pending value.
                    if (bus.I_LOAD[i]) begin
                        n_sh_d = div_in;
                        h_sh_d = high_in;
                        pend_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_clk_divider.sv
// tb/tb_prog_clk_divider.sv - directed self-checking bench for prog_clk_divider
module tb_prog_clk_divider;
    logic I_CLK;
    logic I_RST;

    prog_clk_divider_if #(.NUM_CH(2), .CNT_W(8)) bus ();

    prog_clk_divider #(.NUM_CH(2), .CNT_W(8), .DEF_DIV(10)) dut (
        .I_CLK(I_CLK),
        .I_RST(I_RST),
        .bus  (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    logic [63:0] cap_clk  [2];
    logic [63:0] cap_tick [2];
    logic [63:0] cap_pend [2];
    logic [63:0] exp;

    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic cap_clear();
        for (int c = 0; c < 2; c++) begin
            cap_clk[c] = '0; cap_tick[c] = '0; cap_pend[c] = '0;
        end
    endtask

    // Samples n cycles at negedge, oldest sample ends up leftmost; load pulses last one cycle.
    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge I_CLK);
            for (int c = 0; c < 2; c++) begin
                cap_clk[c]  = {cap_clk[c][62:0],  bus.O_CLK[c]};
                cap_tick[c] = {cap_tick[c][62:0], bus.O_TICK[c]};
                cap_pend[c] = {cap_pend[c][62:0], bus.O_PEND[c]};
            end
            bus.I_LOAD = '0;
        end
    endtask

    task automatic do_reset(input logic [1:0] en);
        bus.I_EN = en;
        I_RST = 1'b1;
        @(negedge I_CLK);
        I_RST = 1'b0;
    endtask

    task automatic load_idle0(input logic [7:0] n, input logic [7:0] h);
        bus.I_EN[0] = 1'b0;
        @(negedge I_CLK);
        bus.I_DIV[7:0]  = n;
        bus.I_HIGH[7:0] = h;
        bus.I_LOAD[0]   = 1'b1;
        @(negedge I_CLK);
        bus.I_LOAD[0] = 1'b0;
        bus.I_EN[0]   = 1'b1;
    endtask

    task automatic test_reset();
        I_RST = 1'b1;
        bus.I_EN = 2'b11; bus.I_LOAD = '0; bus.I_DIV = '0; bus.I_HIGH = '0;
        repeat (2) @(negedge I_CLK);
        total++; if (bus.O_CLK !== 2'b00) begin bad++; $display("FAIL rst_clk got=%b want=00", bus.O_CLK); end
        total++; if (bus.O_TICK !== 2'b00) begin bad++; $display("FAIL rst_tick got=%b want=00", bus.O_TICK); end
        total++; if (bus.O_PEND !== 2'b00) begin bad++; $display("FAIL rst_pend got=%b want=00", bus.O_PEND); end
    endtask

    task automatic test_default();
        I_RST = 1'b0;
        cap_clear();
        capture(20);
        for (int c = 0; c < 2; c++) begin
            exp = 20'b11111000001111100000;
            total++; if (cap_clk[c] !== exp) begin bad++; $display("FAIL dflt_clk%0d got=%h want=%h", c, cap_clk[c], exp); end
            exp = 20'b10000000001000000000;
            total++; if (cap_tick[c] !== exp) begin bad++; $display("FAIL dflt_tick%0d got=%h want=%h", c, cap_tick[c], exp); end
            total++; if (cap_pend[c] !== 64'd0) begin bad++; $display("FAIL dflt_pend%0d got=%h want=0", c, cap_pend[c]); end
        end
    endtask

    task automatic test_idle_load();
        bus.I_EN[0] = 1'b0;
        @(negedge I_CLK);
        total++; if (bus.O_CLK[0] !== 1'b0) begin bad++; $display("FAIL dis_clk got=%b want=0", bus.O_CLK[0]); end
        total++; if (bus.O_TICK[0] !== 1'b0) begin bad++; $display("FAIL dis_tick got=%b want=0", bus.O_TICK[0]); end
        load_idle0(8'd6, 8'd1);
        total++; if (bus.O_PEND[0] !== 1'b0) begin bad++; $display("FAIL idle_pend got=%b want=0", bus.O_PEND[0]); end
        cap_clear();
        capture(12);
        exp = 12'b100000100000;
        total++; if (cap_clk[0] !== exp) begin bad++; $display("FAIL n6_clk got=%h want=%h", cap_clk[0], exp); end
        total++; if (cap_tick[0] !== exp) begin bad++; $display("FAIL n6_tick got=%h want=%h", cap_tick[0], exp); end
    endtask

    task automatic test_mid_load();
        do_reset(2'b11);
        repeat (4) @(negedge I_CLK);
        bus.I_DIV[7:0] = 8'd4; bus.I_HIGH[7:0] = 8'd2; bus.I_LOAD[0] = 1'b1;
        cap_clear();
        capture(14);
        exp = 14'b10000011001100;
        total++; if (cap_clk[0] !== exp) begin bad++; $display("FAIL mid_clk got=%h want=%h", cap_clk[0], exp); end
        exp = 14'b00000010001000;
        total++; if (cap_tick[0] !== exp) begin bad++; $display("FAIL mid_tick got=%h want=%h", cap_tick[0], exp); end
        exp = 14'b11111100000000;
        total++; if (cap_pend[0] !== exp) begin bad++; $display("FAIL mid_pend got=%h want=%h", cap_pend[0], exp); end
    endtask

    task automatic test_boundary();
        load_idle0(8'd0, 8'd1);
        cap_clear(); capture(8);
        exp = 8'b10101010;
        total++; if (cap_clk[0] !== exp) begin bad++; $display("FAIL n0_clk got=%h want=%h", cap_clk[0], exp); end
        total++; if (cap_tick[0] !== exp) begin bad++; $display("FAIL n0_tick got=%h want=%h", cap_tick[0], exp); end
        load_idle0(8'd1, 8'd1);
        cap_clear(); capture(8);
        total++; if (cap_clk[0] !== exp) begin bad++; $display("FAIL n1_clk got=%h want=%h", cap_clk[0], exp); end
        total++; if (cap_tick[0] !== exp) begin bad++; $display("FAIL n1_tick got=%h want=%h", cap_tick[0], exp); end
        load_idle0(8'd5, 8'd0);
        cap_clear(); capture(10);
        total++; if (cap_clk[0] !== 64'd0) begin bad++; $display("FAIL h0_clk got=%h want=0", cap_clk[0]); end
        exp = 10'b1000010000;
        total++; if (cap_tick[0] !== exp) begin bad++; $display("FAIL h0_tick got=%h want=%h", cap_tick[0], exp); end
        load_idle0(8'd8, 8'd255);
        cap_clear(); capture(16);
        exp = 16'hFFFF;
        total++; if (cap_clk[0] !== exp) begin bad++; $display("FAIL hmax_clk got=%h want=%h", cap_clk[0], exp); end
        exp = 16'b1000000010000000;
        total++; if (cap_tick[0] !== exp) begin bad++; $display("FAIL hmax_tick got=%h want=%h", cap_tick[0], exp); end
    endtask

    task automatic test_back_to_back();
        load_idle0(8'd10, 8'd5);
        @(negedge I_CLK);
        bus.I_DIV[7:0] = 8'd3; bus.I_HIGH[7:0] = 8'd1; bus.I_LOAD[0] = 1'b1;
        @(negedge I_CLK);
        bus.I_DIV[7:0] = 8'd7;
        @(negedge I_CLK);
        bus.I_LOAD[0] = 1'b0;
        cap_clear(); capture(21);
        exp = 21'b110000010000001000000;
        total++; if (cap_clk[0] !== exp) begin bad++; $display("FAIL b2b_clk got=%h want=%h", cap_clk[0], exp); end
        exp = 21'b000000010000001000000;
        total++; if (cap_tick[0] !== exp) begin bad++; $display("FAIL b2b_tick got=%h want=%h", cap_tick[0], exp); end
        exp = 21'b111111100000000000000;
        total++; if (cap_pend[0] !== exp) begin bad++; $display("FAIL b2b_pend got=%h want=%h", cap_pend[0], exp); end
        // Last sample is cnt 6 of the 7-cycle period: this load lands on the wrap edge.
        bus.I_DIV[7:0] = 8'd4; bus.I_HIGH[7:0] = 8'd2; bus.I_LOAD[0] = 1'b1;
        cap_clear(); capture(11);
        exp = 11'b10000001100;
        total++; if (cap_clk[0] !== exp) begin bad++; $display("FAIL wrapld_clk got=%h want=%h", cap_clk[0], exp); end
        exp = 11'b10000001000;
        total++; if (cap_tick[0] !== exp) begin bad++; $display("FAIL wrapld_tick got=%h want=%h", cap_tick[0], exp); end
        exp = 11'b11111110000;
        total++; if (cap_pend[0] !== exp) begin bad++; $display("FAIL wrapld_pend got=%h want=%h", cap_pend[0], exp); end
        // Pending 2/1 plus a wrap-edge load of 3/3: 2/1 applies, 3/3 follows one period later.
        cap_clear(); capture(1);
        bus.I_DIV[7:0] = 8'd2; bus.I_HIGH[7:0] = 8'd1; bus.I_LOAD[0] = 1'b1;
        capture(2);
        capture(1);
        bus.I_DIV[7:0] = 8'd3; bus.I_HIGH[7:0] = 8'd3; bus.I_LOAD[0] = 1'b1;
        capture(8);
        exp = 12'b110010111111;
        total++; if (cap_clk[0] !== exp) begin bad++; $display("FAIL prio_clk got=%h want=%h", cap_clk[0], exp); end
        exp = 12'b100010100100;
        total++; if (cap_tick[0] !== exp) begin bad++; $display("FAIL prio_tick got=%h want=%h", cap_tick[0], exp); end
        exp = 12'b011111000000;
        total++; if (cap_pend[0] !== exp) begin bad++; $display("FAIL prio_pend got=%h want=%h", cap_pend[0], exp); end
    endtask

    task automatic test_reset_mid();
        do_reset(2'b11);
        repeat (3) @(negedge I_CLK);
        bus.I_DIV[7:0] = 8'd4; bus.I_HIGH[7:0] = 8'd2; bus.I_LOAD[0] = 1'b1;
        @(negedge I_CLK);
        bus.I_LOAD[0] = 1'b0;
        @(negedge I_CLK);
        total++; if (bus.O_PEND[0] !== 1'b1) begin bad++; $display("FAIL pre_rst_pend got=%b want=1", bus.O_PEND[0]); end
        I_RST = 1'b1;
        #1;
        total++; if (bus.O_CLK !== 2'b00) begin bad++; $display("FAIL arst_clk got=%b want=00", bus.O_CLK); end
        total++; if (bus.O_TICK !== 2'b00) begin bad++; $display("FAIL arst_tick got=%b want=00", bus.O_TICK); end
        total++; if (bus.O_PEND !== 2'b00) begin bad++; $display("FAIL arst_pend got=%b want=00", bus.O_PEND); end
        @(negedge I_CLK);
        I_RST = 1'b0;
        cap_clear(); capture(20);
        exp = 20'b11111000001111100000;
        total++; if (cap_clk[0] !== exp) begin bad++; $display("FAIL rsm_clk got=%h want=%h", cap_clk[0], exp); end
        exp = 20'b10000000001000000000;
        total++; if (cap_tick[0] !== exp) begin bad++; $display("FAIL rsm_tick got=%h want=%h", cap_tick[0], exp); end
        total++; if (cap_pend[0] !== 64'd0) begin bad++; $display("FAIL rsm_pend got=%h want=0", cap_pend[0]); end
    endtask

    task automatic test_isolation();
        cap_clear();
        bus.I_EN[0] = 1'b0;
        capture(3);
        bus.I_DIV[7:0] = 8'd3; bus.I_HIGH[7:0] = 8'd1; bus.I_LOAD[0] = 1'b1;
        capture(3);
        bus.I_EN[0] = 1'b1;
        capture(14);
        exp = 20'b00000010010010010010;
        total++; if (cap_clk[0] !== exp) begin bad++; $display("FAIL iso_clk0 got=%h want=%h", cap_clk[0], exp); end
        total++; if (cap_tick[0] !== exp) begin bad++; $display("FAIL iso_tick0 got=%h want=%h", cap_tick[0], exp); end
        total++; if (cap_pend[0] !== 64'd0) begin bad++; $display("FAIL iso_pend0 got=%h want=0", cap_pend[0]); end
        exp = 20'b11111000001111100000;
        total++; if (cap_clk[1] !== exp) begin bad++; $display("FAIL iso_clk1 got=%h want=%h", cap_clk[1], exp); end
        exp = 20'b10000000001000000000;
        total++; if (cap_tick[1] !== exp) begin bad++; $display("FAIL iso_tick1 got=%h want=%h", cap_tick[1], exp); end
    endtask

    initial begin
        test_reset();
        test_default();
        test_idle_load();
        test_mid_load();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        test_isolation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prog_clk_divider.md
PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent divider channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 24, width of the divide-ratio and high-time fields.
REQ-003 SHALL have parameter DEF_DIV, default 5000000, divide ratio active after reset; DEF_DIV/2 (integer) is the reset high time.
REQ-004 I_CLK  in  1  single system clock, rising edge active.
REQ-005 I_RST  in  1  asynchronous active-high reset.
REQ-006 I_EN  in  NUM_CH  per-channel run enable.
REQ-007 I_LOAD  in  NUM_CH  per-channel single-cycle pulse that captures new settings.
REQ-008 I_DIV  in  NUM_CH*CNT_W  divide ratio N; channel i uses bits [i*CNT_W +: CNT_W].
REQ-009 I_HIGH  in  NUM_CH*CNT_W  high time H in cycles; same packing as I_DIV.
REQ-010 O_CLK  out  NUM_CH  registered divided clock per channel.
REQ-011 O_TICK  out  NUM_CH  registered one-cycle strobe marking the start of each period.
REQ-012 O_PEND  out  NUM_CH  high while captured settings wait to be applied.

Function
REQ-013 Each channel SHALL hold an active (N_act, H_act) pair, a shadow pair, a CNT_W-bit counter cnt, and a two-state FSM IDLE/RUN.
REQ-014 Effective ratio SHALL be max(N_act, 2); N = 0 or 1 is clamped to 2.
REQ-015 IDLE: cnt = 0, O_CLK = 0, O_TICK = 0; moves to RUN on the first edge with I_EN[i] = 1.
REQ-016 On the IDLE->RUN edge: cnt <= 0, O_TICK <= 1, O_CLK <= (H_act > 0).
REQ-017 RUN, each edge: cnt <= (cnt == N_eff-1) ? 0 : cnt+1; O_CLK <= (cnt_next < H_act); O_TICK <= (cnt_next == 0).
REQ-018 Result: period exactly N_eff cycles, O_CLK high for min(H_act, N_eff) cycles starting at the O_TICK cycle.
REQ-019 H_act = 0 SHALL give O_CLK constantly low; H_act >= N_eff constantly high; O_TICK still pulses every period.
REQ-020 RUN with I_EN[i] = 0 SHALL return to IDLE on that edge; O_CLK and O_TICK go 0 on that same edge.
REQ-021 I_LOAD[i] = 1 SHALL copy the I_DIV/I_HIGH fields into the shadow pair and set O_PEND[i] on the same edge.
REQ-022 A pending shadow SHALL become active on the edge where cnt wraps to 0; O_PEND clears on that edge; the new period uses the new values, so no truncated or glitched period occurs.
REQ-023 In IDLE, a load SHALL apply directly to the active pair on the capture edge; O_PEND stays 0.
REQ-024 A load while pending SHALL overwrite the shadow; only the last value is applied.
REQ-025 A load on the wrap edge SHALL take priority: the new values are captured as pending and the old shadow is applied.
REQ-026 Channels SHALL be fully independent; no cross-channel ordering or phase relation is guaranteed except that channels with equal settings, enabled on the same edge, stay phase-aligned.
REQ-027 No logic SHALL be clocked by O_CLK; all state is on I_CLK.

Reset
REQ-028 I_RST = 1 SHALL asynchronously force all channels to IDLE, cnt = 0, N_act = DEF_DIV, H_act = DEF_DIV/2, shadow = active, O_CLK = 0, O_TICK = 0, O_PEND = 0.
REQ-029 Reset mid-period SHALL discard pending loads; after release a channel with I_EN high restarts per REQ-016 on the first edge.

Verification (CNT_W = 8, DEF_DIV = 10 unless stated)
REQ-030 Reset release with I_EN = 1: O_TICK pulses every 10 cycles; O_CLK is 5 high / 5 low; first high cycle coincides with the first O_TICK.
REQ-031 Load N = 6, H = 1 while in IDLE, then enable: O_CLK is a one-cycle pulse every 6 cycles, aligned with O_TICK.
REQ-032 Mid-period load of N = 4, H = 2 at cnt = 3 of a 10-cycle period: O_PEND is high until cnt wraps; the old period completes in full (10 cycles); the next periods are 4 cycles with 2 high.
REQ-033 Boundary ratios: N = 0 and N = 1 each give a period of 2; H = 0 gives O_CLK stuck low with ticks present; H = 255, N = 8 gives O_CLK stuck high.
REQ-034 Two back-to-back loads (N = 3, then N = 7) while pending: only N = 7 is applied. A load on the wrap edge is left pending for the following wrap.
REQ-035 Assert I_RST for 1 cycle mid-period with a load pending: outputs go 0 immediately; O_PEND goes 0; DEF_DIV settings resume. Channel 1 stays undisturbed when only channel 0 is reloaded or disabled.
